// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one single-port synchronous RAM between the instruction
// fetch port and the data port. Data wins conflicts unless fetch has been
// passed over STARVE_LIMIT times in a row. Out-of-range addresses never
// reach the RAM; they complete one cycle later with the error flag set.
module mem_port_arbiter #(
  parameter int unsigned ADDR_W       = 32,
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned RAM_SIZE     = 32'h200000,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  // instruction fetch port
  input  logic              inst_req_i,
  input  logic [ADDR_W-1:0] inst_addr_i,
  output logic              inst_gnt_o,
  output logic              inst_rvalid_o,
  output logic [DATA_W-1:0] inst_rdata_o,
  output logic              inst_err_o,
  // data port
  input  logic              data_req_i,
  input  logic              data_we_i,
  input  logic [3:0]        data_be_i,
  input  logic [ADDR_W-1:0] data_addr_i,
  input  logic [DATA_W-1:0] data_wdata_i,
  output logic              data_gnt_o,
  output logic              data_rvalid_o,
  output logic [DATA_W-1:0] data_rdata_o,
  output logic              data_err_o,
  // RAM port
  output logic              ram_ce_o,
  output logic              ram_we_o,
  output logic [3:0]        ram_be_o,
  output logic [ADDR_W-1:0] ram_addr_o,
  output logic [DATA_W-1:0] ram_wdata_o,
  input  logic [DATA_W-1:0] ram_rdata_i
);

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_INST = 2'd1,
    OWN_DATA = 2'd2
  } owner_e;

  // One extra bit so RAM_SIZE == 2**ADDR_W still compares correctly.
  localparam logic [ADDR_W:0] RAM_END = (ADDR_W+1)'(RAM_SIZE);
  localparam logic [3:0]      LIMIT   = 4'(STARVE_LIMIT);

  logic       inst_in_range;
  logic       data_in_range;
  logic       data_wins;
  logic       grant_inst;
  logic       grant_data;
  logic [3:0] starve_cnt;
  owner_e     resp_owner;
  logic       resp_err;
  logic       resp_we;

  assign inst_in_range = ({1'b0, inst_addr_i} < RAM_END);
  assign data_in_range = ({1'b0, data_addr_i} < RAM_END);

  // Fixed-priority arbitration with a starvation override for fetch.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path
    // through the block leaves it unassigned and no latch is inferred.
    data_wins  = 1'b0;
    grant_inst = 1'b0;
    grant_data = 1'b0;
    if (!rst_i) begin
      data_wins  = data_req_i && !(inst_req_i && (starve_cnt >= LIMIT));
      grant_data = data_wins;
      grant_inst = inst_req_i && !data_wins;
    end
  end

  assign inst_gnt_o = grant_inst;
  assign data_gnt_o = grant_data;

  // Steer the granted requester onto the RAM port; idle port drives zeros.
  always_comb begin
    ram_ce_o    = 1'b0;
    ram_we_o    = 1'b0;
    ram_be_o    = 4'h0;
    ram_addr_o  = '0;
    ram_wdata_o = '0;
    if (grant_data) begin
      ram_ce_o    = data_in_range;
      ram_we_o    = data_we_i;
      ram_be_o    = data_be_i;
      ram_addr_o  = data_addr_i;
      ram_wdata_o = data_wdata_i;
    end else if (grant_inst) begin
      ram_ce_o    = inst_in_range;
      ram_be_o    = 4'hF;
      ram_addr_o  = inst_addr_i;
    end
  end

  // Count consecutive data grants that left a fetch request waiting.
  always_ff @(posedge clk_i) begin
    // NOTE: state is updated with non-blocking assignments so every flop
    // samples the pre-edge values, independent of statement order.
    if (rst_i) begin
      starve_cnt <= 4'd0;
    end else if (!inst_req_i || grant_inst) begin
      starve_cnt <= 4'd0;
    end else if (grant_data && (starve_cnt < LIMIT)) begin
      starve_cnt <= starve_cnt + 4'd1;
    end
  end

  // Remember who owns the response slot of the next cycle.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      resp_owner <= OWN_NONE;
      resp_err   <= 1'b0;
      resp_we    <= 1'b0;
    end else if (grant_data) begin
      resp_owner <= OWN_DATA;
      resp_err   <= !data_in_range;
      resp_we    <= data_we_i;
    end else if (grant_inst) begin
      resp_owner <= OWN_INST;
      resp_err   <= !inst_in_range;
      resp_we    <= 1'b0;
    end else begin
      resp_owner <= OWN_NONE;
      resp_err   <= 1'b0;
      resp_we    <= 1'b0;
    end
  end

  // Response outputs; reset forces them low even if a response is pending.
  assign inst_rvalid_o = !rst_i && (resp_owner == OWN_INST);
  assign data_rvalid_o = !rst_i && (resp_owner == OWN_DATA);
  assign inst_err_o    = inst_rvalid_o && resp_err;
  assign data_err_o    = data_rvalid_o && resp_err;
  assign inst_rdata_o  = (inst_rvalid_o && !resp_err) ? ram_rdata_i : '0;
  assign data_rdata_o  = (data_rvalid_o && !resp_err && !resp_we) ? ram_rdata_i : '0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios with literal
// expectations, then randomized traffic compared every cycle against a
// behavioural model of arbitration, RAM contents and response timing.
module tb_mem_port_arbiter;

  localparam int unsigned RAM_SIZE = 32'h200000;
  localparam int unsigned LIMIT    = 4;
  localparam int unsigned WORDS    = RAM_SIZE / 4;

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic        inst_req_i = 1'b0;
  logic [31:0] inst_addr_i = '0;
  logic        inst_gnt_o, inst_rvalid_o, inst_err_o;
  logic [31:0] inst_rdata_o;
  logic        data_req_i = 1'b0;
  logic        data_we_i = 1'b0;
  logic [3:0]  data_be_i = '0;
  logic [31:0] data_addr_i = '0;
  logic [31:0] data_wdata_i = '0;
  logic        data_gnt_o, data_rvalid_o, data_err_o;
  logic [31:0] data_rdata_o;
  logic        ram_ce_o, ram_we_o;
  logic [3:0]  ram_be_o;
  logic [31:0] ram_addr_o, ram_wdata_o;
  logic [31:0] ram_rdata_i;

  mem_port_arbiter #(
    .ADDR_W(32), .DATA_W(32), .RAM_SIZE(RAM_SIZE), .STARVE_LIMIT(LIMIT)
  ) dut (
    .clk_i(clk), .rst_i(rst_i),
    .inst_req_i(inst_req_i), .inst_addr_i(inst_addr_i), .inst_gnt_o(inst_gnt_o),
    .inst_rvalid_o(inst_rvalid_o), .inst_rdata_o(inst_rdata_o), .inst_err_o(inst_err_o),
    .data_req_i(data_req_i), .data_we_i(data_we_i), .data_be_i(data_be_i),
    .data_addr_i(data_addr_i), .data_wdata_i(data_wdata_i), .data_gnt_o(data_gnt_o),
    .data_rvalid_o(data_rvalid_o), .data_rdata_o(data_rdata_o), .data_err_o(data_err_o),
    .ram_ce_o(ram_ce_o), .ram_we_o(ram_we_o), .ram_be_o(ram_be_o),
    .ram_addr_o(ram_addr_o), .ram_wdata_o(ram_wdata_o), .ram_rdata_i(ram_rdata_i)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got 0x%08h expected 0x%08h", name, $time, act, exp);
    end
  endtask

  function automatic bit [31:0] merge(input bit [31:0] old, input bit [31:0] wd, input bit [3:0] be);
    bit [31:0] r;
    for (int i = 0; i < 4; i++) r[8*i +: 8] = be[i] ? wd[8*i +: 8] : old[8*i +: 8];
    return r;
  endfunction

  // The RAM the arbiter drives: synchronous read, byte-enabled write.
  bit [31:0] ram_mem [0:WORDS-1];
  bit [31:0] ram_q = '0;
  assign ram_rdata_i = ram_q;

  always @(posedge clk) begin
    if (ram_ce_o) begin
      if (ram_we_o) ram_mem[ram_addr_o[20:2]] <= merge(ram_mem[ram_addr_o[20:2]], ram_wdata_o, ram_be_o);
      else          ram_q <= ram_mem[ram_addr_o[20:2]];
    end
  end

  // Reference model state: expected memory, pending response, and how many
  // times in a row fetch has been passed over in favour of data.
  bit [31:0]   m_mem [0:WORDS-1];
  int unsigned passed_over = 0;
  int          pend_owner = 0;   // 0 none, 1 fetch, 2 data
  bit          pend_err = 1'b0;
  bit [31:0]   pend_rdata = '0;
  bit          last_gi = 1'b0;
  bit          last_gd = 1'b0;

  // Compare process: mid-cycle, derive every output from the rules and check.
  initial begin
    forever begin
      bit gi, gd, ce, we, irv, drv;
      bit [3:0] be;
      bit [31:0] a, wd;
      @(negedge clk);
      gi = 0; gd = 0; ce = 0; we = 0; be = 0; a = 0; wd = 0;
      if (!rst_i) begin
        gd = data_req_i && !(inst_req_i && passed_over >= LIMIT);
        gi = inst_req_i && !gd;
        if (gd) begin
          a = data_addr_i; we = data_we_i; be = data_be_i; wd = data_wdata_i;
          ce = (a < RAM_SIZE);
        end else if (gi) begin
          a = inst_addr_i; be = 4'hF;
          ce = (a < RAM_SIZE);
        end
      end
      irv = !rst_i && pend_owner == 1;
      drv = !rst_i && pend_owner == 2;

      check("inst_gnt", inst_gnt_o, gi);
      check("data_gnt", data_gnt_o, gd);
      check("ram_ce", ram_ce_o, ce);
      check("ram_we", ram_we_o, we);
      check("ram_be", ram_be_o, be);
      check("ram_addr", ram_addr_o, a);
      if (gd) check("ram_wdata", ram_wdata_o, wd);
      check("inst_rvalid", inst_rvalid_o, irv);
      check("data_rvalid", data_rvalid_o, drv);
      check("inst_rdata", inst_rdata_o, irv ? pend_rdata : 32'h0);
      check("data_rdata", data_rdata_o, drv ? pend_rdata : 32'h0);
      if (irv) check("inst_err", inst_err_o, pend_err);
      if (drv) check("data_err", data_err_o, pend_err);

      if (rst_i) begin
        passed_over = 0; pend_owner = 0; pend_err = 0; pend_rdata = 0;
      end else begin
        pend_owner = gd ? 2 : (gi ? 1 : 0);
        pend_err   = (gd || gi) && !ce;
        pend_rdata = (ce && !we) ? m_mem[a[20:2]] : 32'h0;
        if (ce && we) m_mem[a[20:2]] = merge(m_mem[a[20:2]], wd, be);
        if (!inst_req_i || gi) passed_over = 0;
        else if (gd)           passed_over++;
      end
      last_gi = gi;
      last_gd = gd;
    end
  end

  task automatic next_cycle();
    @(posedge clk); #1;
  endtask

  task automatic mid_cycle();
    @(negedge clk); #1;
  endtask

  function automatic logic [31:0] pick_addr();
    case ($urandom_range(0, 9))
      0:       return 32'h0020_0000;
      1:       return 32'h001F_FFFC;
      2:       return 32'hFFFF_FFFC;
      3:       return 32'h0000_0100;
      default: return 32'($urandom_range(0, 15)) * 4;
    endcase
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    string exp_s;
    byte   g;
    bit    prev_i, prev_d;

    ram_mem[32'h100 >> 2] = 32'h0000_0013;  m_mem[32'h100 >> 2] = 32'h0000_0013;
    ram_mem[0]            = 32'h1122_3344;  m_mem[0]            = 32'h1122_3344;

    repeat (3) next_cycle();
    mid_cycle();
    check("reset_inst_gnt", inst_gnt_o, 1'b0);
    check("reset_ram_ce", ram_ce_o, 1'b0);
    next_cycle();
    rst_i = 1'b0;

    // Fetch only: three back-to-back fetches of 0x100.
    inst_req_i = 1; inst_addr_i = 32'h100;
    for (int k = 0; k < 3; k++) begin
      mid_cycle();
      check("fo_gnt", inst_gnt_o, 1'b1);
      check("fo_ce", ram_ce_o, 1'b1);
      if (k > 0) begin
        check("fo_rvalid", inst_rvalid_o, 1'b1);
        check("fo_rdata", inst_rdata_o, 32'h0000_0013);
      end
      next_cycle();
    end
    inst_req_i = 0;
    mid_cycle();
    check("fo_rvalid_last", inst_rvalid_o, 1'b1);
    check("fo_rdata_last", inst_rdata_o, 32'h0000_0013);
    next_cycle();

    // Partial write then read back.
    data_req_i = 1; data_we_i = 1; data_be_i = 4'b0011;
    data_addr_i = 32'h2000; data_wdata_i = 32'hDEAD_BEEF;
    mid_cycle();
    check("wr_gnt", data_gnt_o, 1'b1);
    next_cycle();
    data_we_i = 0;
    mid_cycle();
    check("wr_rvalid", data_rvalid_o, 1'b1);
    check("wr_rdata", data_rdata_o, 32'h0);
    next_cycle();
    data_req_i = 0;
    mid_cycle();
    check("rd_rvalid", data_rvalid_o, 1'b1);
    check("rd_rdata", data_rdata_o, 32'h0000_BEEF);
    next_cycle();

    // Conflict: both held for 12 cycles.
    exp_s = "DDDDIDDDDIDD";
    inst_req_i = 1; inst_addr_i = 32'h100;
    data_req_i = 1; data_we_i = 0; data_addr_i = 32'h2000;
    prev_i = 0; prev_d = 0;
    for (int k = 0; k < 12; k++) begin
      mid_cycle();
      g = inst_gnt_o ? "I" : (data_gnt_o ? "D" : "-");
      check("starve_seq", g, exp_s[k]);
      if (k > 0) begin
        check("starve_irv", inst_rvalid_o, prev_i);
        check("starve_drv", data_rvalid_o, prev_d);
      end
      prev_i = inst_gnt_o; prev_d = data_gnt_o;
      next_cycle();
    end

    // Out-of-range write must not touch word 0.
    inst_req_i = 0;
    data_req_i = 1; data_we_i = 1; data_be_i = 4'hF;
    data_addr_i = 32'h0020_0000; data_wdata_i = 32'hCAFE_F00D;
    mid_cycle();
    check("oor_gnt", data_gnt_o, 1'b1);
    check("oor_ce", ram_ce_o, 1'b0);
    next_cycle();
    data_we_i = 0; data_addr_i = 32'h0;
    mid_cycle();
    check("oor_rvalid", data_rvalid_o, 1'b1);
    check("oor_err", data_err_o, 1'b1);
    next_cycle();
    data_req_i = 0;
    mid_cycle();
    check("oor_rd0_err", data_err_o, 1'b0);
    check("oor_rd0", data_rdata_o, 32'h1122_3344);
    next_cycle();

    // Reset right after a granted read, with fetch already passed over.
    inst_req_i = 1; inst_addr_i = 32'h100;
    data_req_i = 1; data_addr_i = 32'h100;
    repeat (3) next_cycle();
    rst_i = 1;
    mid_cycle();
    check("rst_drv", data_rvalid_o, 1'b0);
    check("rst_dgnt", data_gnt_o, 1'b0);
    check("rst_ce", ram_ce_o, 1'b0);
    next_cycle();
    mid_cycle();
    check("rst_drv2", data_rvalid_o, 1'b0);
    next_cycle();
    rst_i = 0;
    exp_s = "DDDDI";
    for (int k = 0; k < 5; k++) begin
      mid_cycle();
      if (k == 0) begin
        check("post_rst_drv", data_rvalid_o, 1'b0);
        check("post_rst_irv", inst_rvalid_o, 1'b0);
      end
      g = inst_gnt_o ? "I" : (data_gnt_o ? "D" : "-");
      check("post_rst_seq", g, exp_s[k]);
      next_cycle();
    end

    // Interleave: alternate single requesters every cycle.
    inst_req_i = 0; data_req_i = 0;
    inst_addr_i = 32'h100; data_addr_i = 32'h2000; data_we_i = 0;
    for (int k = 0; k < 8; k++) begin
      inst_req_i = (k % 2 == 1);
      data_req_i = (k % 2 == 0);
      mid_cycle();
      check("il_gnt", (k % 2 == 0) ? data_gnt_o : inst_gnt_o, 1'b1);
      if (k > 0 && k % 2 == 1) check("il_drdata", data_rdata_o, 32'h0000_BEEF);
      if (k > 0 && k % 2 == 0) check("il_irdata", inst_rdata_o, 32'h0000_0013);
      next_cycle();
    end
    inst_req_i = 0; data_req_i = 0;
    mid_cycle();
    check("il_last_irv", inst_rvalid_o, 1'b1);
    next_cycle();

    // Randomized traffic; requests stay up until the model says granted.
    for (int c = 0; c < 3000; c++) begin
      rst_i = ($urandom_range(0, 199) == 0);
      if (!inst_req_i || last_gi) begin
        inst_req_i  = ($urandom_range(0, 3) != 0);
        inst_addr_i = pick_addr();
      end
      if (!data_req_i || last_gd) begin
        data_req_i   = ($urandom_range(0, 2) != 0);
        data_we_i    = $urandom_range(0, 1) == 1;
        data_be_i    = 4'($urandom_range(0, 15));
        data_addr_i  = pick_addr();
        data_wdata_i = $urandom;
      end
      next_cycle();
    end
    rst_i = 0; inst_req_i = 0; data_req_i = 0;
    repeat (3) next_cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-port synchronous RAM between the instruction-fetch requester (IF stage) and the data requester (MEM stage).
- Data has priority, because it is the older instruction in the pipeline. A starvation guard guarantees that fetch makes progress.
- The block gives a req/gnt/rvalid handshake to each requester, and the pipeline derives its stalls from gnt/rvalid.
- Addresses at or above RAM_SIZE are never issued to the RAM. They complete with an error flag.

Parameters:
- ADDR_W, 32: address width of both requesters and the RAM port.
- DATA_W, 32: data width.
- RAM_SIZE, 32'h200000: RAM size in bytes. Addresses >= RAM_SIZE are out of range.
- STARVE_LIMIT, 4: maximum consecutive data grants while fetch waits. Legal range 1..15.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset.
- inst_req_i  in  1  fetch request; held until granted.
- inst_addr_i  in  ADDR_W  fetch byte address; word-aligned.
- inst_gnt_o  out  1  fetch request accepted this cycle.
- inst_rvalid_o  out  1  fetch data valid.
- inst_rdata_o  out  DATA_W  fetch data.
- inst_err_o  out  1  fetch address was out of range; qualified by inst_rvalid_o.
- data_req_i  in  1  data request; held until granted.
- data_we_i  in  1  1 = write, 0 = read.
- data_be_i  in  4  byte enables for writes.
- data_addr_i  in  ADDR_W  data byte address.
- data_wdata_i  in  DATA_W  write data.
- data_gnt_o  out  1  data request accepted this cycle.
- data_rvalid_o  out  1  data access completed; read data valid.
- data_rdata_o  out  DATA_W  read data.
- data_err_o  out  1  data address was out of range; qualified by data_rvalid_o.
- ram_ce_o  out  1  RAM access enable.
- ram_we_o  out  1  RAM write.
- ram_be_o  out  4  RAM byte enables.
- ram_addr_o  out  ADDR_W  RAM byte address.
- ram_wdata_o  out  DATA_W  RAM write data.
- ram_rdata_i  in  DATA_W  RAM read data; valid the cycle after a read with ram_ce_o=1.

Behaviour:
- Clock and reset: single clock clk_i. rst_i is synchronous and active-high.
- Reset:
  - While rst_i=1: all outputs are 0, including the combinational grants and ram_ce_o.
  - On the edge with rst_i=1: resp_owner, resp_err, the rvalid registers and starve_cnt are cleared.
  - An access issued in the cycle before reset produces no rvalid after reset. The RAM write itself may already have happened.
- Arbitration (combinational, each cycle):
  - Only data requesting: grant data.
  - Only fetch requesting: grant fetch.
  - Both requesting, starve_cnt < STARVE_LIMIT: grant data.
  - Both requesting, starve_cnt == STARVE_LIMIT: grant fetch.
  - At most one grant per cycle. The requester's gnt is asserted in the same cycle as its req.
- RAM issue:
  - For the granted requester, ram_addr/we/be/wdata are muxed combinationally from that requester. Fetch always issues we=0 and be=4'hF.
  - ram_ce_o = grant & in_range, where in_range = (addr < RAM_SIZE).
  - When there is no grant: ram_ce_o=0, and the other RAM outputs are 0.
- Starvation counter starve_cnt (4 bits):
  - Increments on each cycle where data is granted and inst_req_i=1.
  - Clears on a fetch grant, or on any cycle with inst_req_i=0.
  - Never exceeds STARVE_LIMIT.
- Response (one cycle of latency):
  - Registers: resp_owner (none/inst/data) and resp_err are registered at each grant.
  - Next cycle, the owner's rvalid is 1.
  - Reads: rdata = ram_rdata_i passed through combinationally, or 0 if resp_err=1.
  - Writes: data_rvalid_o=1 and data_rdata_o=0.
  - err_o = resp_err.
  - rdata outputs are 0 whenever the matching rvalid=0.
- Pipelining: back-to-back grants are legal every cycle, giving throughput of 1 access/cycle. The response of cycle N coexists with the grant of cycle N+1.
- Out-of-range addresses:
  - No RAM access and no write side effect.
  - Still granted, with rvalid the next cycle and err=1.
- Misaligned addresses are the requesters' responsibility. The arbiter passes them through unchanged.

Test Plan:
- Fetch only:
  - Stimulus: inst_req=1 at addr 0x100 for 3 cycles; RAM preloaded word 0x100=0x00000013.
  - Required: gnt in each cycle, ram_ce each cycle, rvalid the cycle after each grant with rdata 0x00000013.
- Data write then read, fetch idle:
  - Stimulus: write 0xDEADBEEF, be=4'b0011, to 0x2000 (old value 0). Then read 0x2000.
  - Required: read returns 0x0000BEEF. Write rvalid with rdata 0. No inst grants.
- Conflict/starvation, STARVE_LIMIT=4:
  - Stimulus: both requests held for 12 cycles.
  - Required grant sequence: D D D D I D D D D I D D. rvalid owners follow one cycle later.
- Out-of-range:
  - Stimulus: data write to 0x00200000.
  - Required: data_gnt=1, ram_ce=0. Next cycle data_rvalid=1 and data_err=1. A subsequent read of 0x0 is unchanged.
- Reset mid-operation:
  - Stimulus: grant a read; assert rst_i in the following cycle.
  - Required: rvalid stays 0 in that cycle and after; starve_cnt is 0; first post-reset conflict grants data.
- Interleave:
  - Stimulus: alternate data/fetch requests on consecutive cycles.
  - Required: no bubble. Each rvalid arrives exactly 1 cycle after its grant, with correct owner and data.
